// File: rtl/bot_if_pkg.sv
// Shared definitions for the Rojobot I/O port bus: port map, arbiter state
// encoding and requester indices.
package bot_if_pkg;

    localparam int unsigned PORT_W = 8;

    // Read ports
    localparam logic [PORT_W-1:0] PA_PBTNS    = 8'h00;
    localparam logic [PORT_W-1:0] PA_SLSWTCH  = 8'h01;
    localparam logic [PORT_W-1:0] PA_LOCX     = 8'h0A;
    localparam logic [PORT_W-1:0] PA_LOCY     = 8'h0B;
    localparam logic [PORT_W-1:0] PA_BOTINFO  = 8'h0C;
    localparam logic [PORT_W-1:0] PA_SENSORS  = 8'h0D;

    // Write ports
    localparam logic [PORT_W-1:0] PA_LEDS     = 8'h02;
    localparam logic [PORT_W-1:0] PA_DIG3     = 8'h03;
    localparam logic [PORT_W-1:0] PA_DIG2     = 8'h04;
    localparam logic [PORT_W-1:0] PA_DIG1     = 8'h05;
    localparam logic [PORT_W-1:0] PA_DIG0     = 8'h06;
    localparam logic [PORT_W-1:0] PA_DP       = 8'h07;
    localparam logic [PORT_W-1:0] PA_MOTCTL   = 8'h09;

    // Requester indices
    localparam logic REQ_APP  = 1'b0;
    localparam logic REQ_HOST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_e;

    // One requester's access as sampled at grant
    typedef struct packed {
        logic              we;
        logic [PORT_W-1:0] addr;
        logic [PORT_W-1:0] wdata;
    } bus_acc_t;

endpackage

// File: rtl/bot_rr_pick.sv
// Two-input round-robin picker with a lock that restricts eligibility to
// requester 0 and a one-shot override that hands the next tie to requester 1.
module bot_rr_pick
    import bot_if_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic lock_hold,
    input  logic force_host,
    input  logic rr_last,
    output logic valid,
    output logic winner,
    output logic rr_next
);

    always_comb begin
        valid  = 1'b0;
        winner = REQ_APP;
        if (lock_hold) begin
            valid  = req0;
            winner = REQ_APP;
        end else if (req0 && req1) begin
            valid  = 1'b1;
            winner = (force_host || (rr_last == REQ_APP)) ? REQ_HOST : REQ_APP;
        end else if (req0 || req1) begin
            valid  = 1'b1;
            winner = req1 ? REQ_HOST : REQ_APP;
        end
    end

    assign rr_next = valid ? winner : rr_last;

endmodule

// File: rtl/bot_port_arbiter.sv
// Shares the Rojobot I/O port bus between the PicoBlaze application and a
// debug host: one strobe cycle per access, read data returned with done.
module bot_port_arbiter
    import bot_if_pkg::*;
#(
    parameter int unsigned LOCK_MAX = 64,
    parameter int unsigned LOCK_CW  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [PORT_W-1:0] addr0,
    input  logic [PORT_W-1:0] addr1,
    input  logic [PORT_W-1:0] wdata0,
    input  logic [PORT_W-1:0] wdata1,
    input  logic              lock0,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [PORT_W-1:0] rdata0,
    output logic [PORT_W-1:0] rdata1,
    output logic              lock_err,
    output logic              busy,
    output logic              Wr_Strobe,
    output logic              Rd_Strobe,
    output logic [PORT_W-1:0] AddrIn,
    output logic [PORT_W-1:0] DataIn,
    input  logic [PORT_W-1:0] DataOut
);

    arb_state_e         state;
    logic               rr_last;
    logic               cur_who;
    logic               cur_we;
    logic               lock_owned;
    logic               force_host;
    logic [LOCK_CW-1:0] lock_timer;

    logic     lock_timeout;
    logic     lock_release;
    logic     lock_hold;
    logic     pick_force;
    logic     pick_req0;
    logic     pick_req1;
    logic     pick_valid;
    logic     pick_winner;
    logic     pick_rr_next;
    bus_acc_t acc0;
    bus_acc_t acc1;
    bus_acc_t sel_acc;

    // Lock bookkeeping: a timeout overrides everything, release only counts in IDLE
    assign lock_timeout = lock_owned && (lock_timer == LOCK_CW'(LOCK_MAX));
    assign lock_release = lock_owned && (state == ST_IDLE) && !lock0;
    assign lock_hold    = lock_owned && !lock_timeout && !lock_release;
    assign pick_force   = force_host || lock_timeout;

    // Requests only matter while IDLE; everywhere else they are ignored
    assign pick_req0 = req0 && (state == ST_IDLE);
    assign pick_req1 = req1 && (state == ST_IDLE);

    assign acc0    = '{we: we0, addr: addr0, wdata: wdata0};
    assign acc1    = '{we: we1, addr: addr1, wdata: wdata1};
    assign sel_acc = (pick_winner == REQ_HOST) ? acc1 : acc0;

    bot_rr_pick u_pick (
        .req0       (pick_req0),
        .req1       (pick_req1),
        .lock_hold  (lock_hold),
        .force_host (pick_force),
        .rr_last    (rr_last),
        .valid      (pick_valid),
        .winner     (pick_winner),
        .rr_next    (pick_rr_next)
    );

    // Access sequencer, bus drive and lock timer
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            rr_last    <= REQ_HOST;
            cur_who    <= REQ_APP;
            cur_we     <= 1'b0;
            lock_owned <= 1'b0;
            force_host <= 1'b0;
            lock_timer <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            lock_err   <= 1'b0;
            busy       <= 1'b0;
            Wr_Strobe  <= 1'b0;
            Rd_Strobe  <= 1'b0;
            AddrIn     <= '0;
            DataIn     <= '0;
        end else begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            lock_err  <= 1'b0;
            Wr_Strobe <= 1'b0;
            Rd_Strobe <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        cur_who   <= pick_winner;
                        cur_we    <= sel_acc.we;
                        rr_last   <= pick_rr_next;
                        AddrIn    <= sel_acc.addr;
                        DataIn    <= sel_acc.wdata;
                        Wr_Strobe <= sel_acc.we;
                        Rd_Strobe <= !sel_acc.we;
                        gnt0      <= (pick_winner == REQ_APP);
                        gnt1      <= (pick_winner == REQ_HOST);
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cur_we) begin
                        done0 <= (cur_who == REQ_APP);
                        done1 <= (cur_who == REQ_HOST);
                        state <= ST_DONE;
                    end else begin
                        state <= ST_RDWAIT;
                    end
                end
                ST_RDWAIT: begin
                    // DataOut now reflects AddrIn registered by the interface
                    if (cur_who == REQ_APP) begin
                        rdata0 <= DataOut;
                    end else begin
                        rdata1 <= DataOut;
                    end
                    done0 <= (cur_who == REQ_APP);
                    done1 <= (cur_who == REQ_HOST);
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase

            if ((state == ST_DONE) && (cur_who == REQ_APP) && lock0) begin
                lock_owned <= 1'b1;
            end

            if (lock_timeout) begin
                lock_owned <= 1'b0;
                lock_timer <= '0;
                lock_err   <= 1'b1;
                force_host <= 1'b1;
            end else if (lock_release) begin
                lock_owned <= 1'b0;
                lock_timer <= '0;
            end else if (lock_owned) begin
                lock_timer <= lock_timer + LOCK_CW'(1);
            end

            // The override is consumed by the arbitration that used it
            if ((state == ST_IDLE) && pick_valid) begin
                force_host <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bot_port_arbiter.sv
// Scoreboard bench for bot_port_arbiter: instance A uses the default lock
// limit, instance B a short one for the forced lock break.
module tb_bot_port_arbiter;

    typedef struct {
        int         who;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        bit         lock;
        logic [7:0] rd0;
        logic [7:0] rd1;
    } txn_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock0 = 1'b0;
    logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;

    logic a_gnt0, a_gnt1, a_done0, a_done1, a_lock_err, a_busy, a_wr, a_rd;
    logic [7:0] a_rdata0, a_rdata1, a_addr, a_data;
    logic [7:0] a_dout = '0;
    logic b_gnt0, b_gnt1, b_done0, b_done1, b_lock_err, b_busy, b_wr, b_rd;
    logic [7:0] b_rdata0, b_rdata1, b_addr, b_data;
    logic [7:0] b_dout = '0;

    bit sel = 1'b0;
    logic gnt0_s, gnt1_s, done0_s, done1_s, lock_err_s, busy_s, wr_s, rd_s;
    logic [7:0] rdata0_s, rdata1_s, addr_s, data_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    txn_t exp_q[$];
    txn_t r0_q[$];
    txn_t r1_q[$];
    txn_t cur;
    bit inflight = 1'b0;
    int gnt_cyc = 0;
    int last_gnt1_cyc = 0;
    int lock_drop_cyc = 0;
    int lock_err_cnt = 0;
    logic [7:0] m_rd0 = '0, m_rd1 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bot_port_arbiter u_dut_a (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .lock0(lock0),
        .gnt0(a_gnt0), .gnt1(a_gnt1), .done0(a_done0), .done1(a_done1),
        .rdata0(a_rdata0), .rdata1(a_rdata1), .lock_err(a_lock_err), .busy(a_busy),
        .Wr_Strobe(a_wr), .Rd_Strobe(a_rd), .AddrIn(a_addr), .DataIn(a_data),
        .DataOut(a_dout)
    );

    bot_port_arbiter #(.LOCK_MAX(8), .LOCK_CW(4)) u_dut_b (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .lock0(lock0),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
        .rdata0(b_rdata0), .rdata1(b_rdata1), .lock_err(b_lock_err), .busy(b_busy),
        .Wr_Strobe(b_wr), .Rd_Strobe(b_rd), .AddrIn(b_addr), .DataIn(b_data),
        .DataOut(b_dout)
    );

    assign gnt0_s     = sel ? b_gnt0     : a_gnt0;
    assign gnt1_s     = sel ? b_gnt1     : a_gnt1;
    assign done0_s    = sel ? b_done0    : a_done0;
    assign done1_s    = sel ? b_done1    : a_done1;
    assign lock_err_s = sel ? b_lock_err : a_lock_err;
    assign busy_s     = sel ? b_busy     : a_busy;
    assign wr_s       = sel ? b_wr       : a_wr;
    assign rd_s       = sel ? b_rd       : a_rd;
    assign rdata0_s   = sel ? b_rdata0   : a_rdata0;
    assign rdata1_s   = sel ? b_rdata1   : a_rdata1;
    assign addr_s     = sel ? b_addr     : a_addr;
    assign data_s     = sel ? b_data     : a_data;

    function automatic logic [7:0] rom(input logic [7:0] a);
        case (a)
            8'h0A:   return 8'h5C;
            8'h0B:   return 8'h6D;
            8'h0C:   return 8'h7E;
            default: return 8'hA5 ^ a;
        endcase
    endfunction

    // Register interface: read data registered on the presented address
    always @(posedge clk) begin
        a_dout <= rom(a_addr);
        b_dout <= rom(b_addr);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: pops the expected transaction at grant, checks bus and completion
    always @(negedge clk) begin
        if (reset) begin
            inflight = 1'b0;
        end else begin
            if (wr_s && rd_s) chk("both_strobes", 64'(1), 64'(0));
            if (lock_err_s) lock_err_cnt++;
            if (gnt0_s || gnt1_s) begin
                if (gnt1_s) last_gnt1_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("gnt_unexpected", 64'({gnt1_s, gnt0_s}), 64'(0));
                end else begin
                    cur = exp_q.pop_front();
                    inflight = 1'b1;
                    gnt_cyc = cyc;
                    chk("gnt_who", 64'({gnt1_s, gnt0_s}), 64'((cur.who == 1) ? 2'b10 : 2'b01));
                end
            end
            if (wr_s || rd_s) begin
                chk("bus_cycle",
                    64'({inflight, (cyc == gnt_cyc), busy_s, wr_s, rd_s, addr_s, data_s}),
                    64'({1'b1, 1'b1, 1'b1, cur.we, !cur.we, cur.addr, cur.wdata}));
            end
            if (done0_s || done1_s) begin
                if (!inflight) begin
                    chk("done_unexpected", 64'({done1_s, done0_s}), 64'(0));
                end else begin
                    chk("done_resp",
                        64'({done1_s, done0_s, 8'(cyc - gnt_cyc), rdata0_s, rdata1_s}),
                        64'({(cur.who == 1), (cur.who == 0), 8'(cur.we ? 1 : 2), cur.rd0, cur.rd1}));
                    inflight = 1'b0;
                end
            end
        end
    end

    task automatic add(input int who, input bit we, input logic [7:0] addr,
                       input logic [7:0] wdata, input bit lock);
        txn_t t;
        if (!we) begin
            if (who == 0) m_rd0 = rom(addr);
            else          m_rd1 = rom(addr);
        end
        t.who = who; t.we = we; t.addr = addr; t.wdata = wdata; t.lock = lock;
        t.rd0 = m_rd0; t.rd1 = m_rd1;
        exp_q.push_back(t);
        if (who == 0) r0_q.push_back(t);
        else          r1_q.push_back(t);
    endtask

    // Requester driver: holds req across its list, new access presented on done
    task automatic run_req(input int who);
        txn_t t;
        bit got;
        while ((who == 0 && r0_q.size() > 0) || (who == 1 && r1_q.size() > 0)) begin
            if (who == 0) begin
                t = r0_q.pop_front();
                we0 = t.we; addr0 = t.addr; wdata0 = t.wdata; lock0 = t.lock; req0 = 1'b1;
            end else begin
                t = r1_q.pop_front();
                we1 = t.we; addr1 = t.addr; wdata1 = t.wdata; req1 = 1'b1;
            end
            got = 1'b0;
            for (int c = 0; c < 80 && !got; c++) begin
                @(posedge clk); #1;
                got = (who == 0) ? done0_s : done1_s;
            end
            chk($sformatf("req%0d_done_seen", who), 64'(got), 64'(1));
        end
        if (who == 0) begin
            req0 = 1'b0; lock0 = 1'b0; lock_drop_cyc = cyc;
        end else begin
            req1 = 1'b0;
        end
    endtask

    task automatic run_both();
        fork
            run_req(0);
            run_req(1);
        join
        repeat (3) @(posedge clk);
        #1;
        chk("exp_drained", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_rd0 = '0; m_rd1 = '0;
        exp_q.delete(); r0_q.delete(); r1_q.delete();
    endtask

    initial begin
        bit seen;
        do_reset();
        chk("reset_state_a", 64'({a_gnt0, a_gnt1, a_done0, a_done1, a_lock_err, a_busy, a_wr, a_rd,
                                  a_rdata0, a_rdata1, a_addr, a_data}), 64'(0));
        chk("reset_state_b", 64'({b_gnt0, b_gnt1, b_done0, b_done1, b_lock_err, b_busy, b_wr, b_rd,
                                  b_rdata0, b_rdata1, b_addr, b_data}), 64'(0));

        // Single write, then single read from the host
        add(0, 1'b1, 8'h09, 8'h33, 1'b0);
        run_both();
        add(1, 1'b0, 8'h0A, 8'h00, 1'b0);
        run_both();

        // Contention from reset: grants alternate 0,1,0,1
        do_reset();
        add(0, 1'b0, 8'h0B, 8'h00, 1'b0);
        add(1, 1'b1, 8'h20, 8'h11, 1'b0);
        add(0, 1'b1, 8'h21, 8'h22, 1'b0);
        add(1, 1'b0, 8'h0C, 8'h00, 1'b0);
        run_both();

        // Locked snapshot: host waits out three application reads
        lock_err_cnt = 0;
        add(0, 1'b0, 8'h0A, 8'h00, 1'b1);
        add(0, 1'b0, 8'h0B, 8'h00, 1'b1);
        add(0, 1'b0, 8'h0C, 8'h00, 1'b1);
        add(1, 1'b1, 8'h30, 8'h44, 1'b0);
        run_both();
        chk("lock_release_to_gnt1",
            64'((last_gnt1_cyc - lock_drop_cyc >= 1) && (last_gnt1_cyc - lock_drop_cyc <= 2)), 64'(1));
        chk("lock_err_none", 64'(lock_err_cnt), 64'(0));

        // Reset while waiting for read data
        do_reset();
        add(1, 1'b0, 8'h0A, 8'h00, 1'b0);
        r1_q.delete();
        we1 = 1'b0; addr1 = 8'h0A; wdata1 = 8'h00; req1 = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            seen = gnt1_s;
        end
        chk("abort_gnt_seen", 64'(seen), 64'(1));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_quiet", 64'({busy_s, wr_s, rd_s, done0_s, done1_s}), 64'(0));
        reset = 1'b0; req1 = 1'b0;
        m_rd0 = '0; m_rd1 = '0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", 64'({a_done0, a_done1, a_rdata1}), 64'(0));
        add(1, 1'b0, 8'h0A, 8'h00, 1'b0);
        run_both();

        // Forced lock break on the short-limit instance
        sel = 1'b1;
        do_reset();
        lock_err_cnt = 0;
        add(0, 1'b1, 8'h40, 8'h01, 1'b1);
        add(0, 1'b1, 8'h41, 8'h02, 1'b1);
        add(0, 1'b1, 8'h42, 8'h03, 1'b1);
        add(0, 1'b1, 8'h43, 8'h04, 1'b1);
        add(1, 1'b1, 8'h50, 8'h55, 1'b0);
        add(0, 1'b1, 8'h44, 8'h05, 1'b1);
        run_both();
        chk("lock_err_once", 64'(lock_err_cnt), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bot_port_arbiter.md
Name: bot_port_arbiter

Overview:
- Shares the single PicoBlaze-style I/O port bus of the Rojobot register interface between two masters.
  - Requester 0: PicoBlaze application.
  - Requester 1: debug/host master.
- Serialises accesses and drives the bus strobes and address for exactly one cycle per access.
- Waits out the interface's one-cycle registered read latency, then returns read data with a done pulse.
- Round-robin fairness, plus an optional lock so requester 0 can perform atomic multi-register snapshots.

Parameters:
- LOCK_MAX, 64: maximum consecutive cycles requester 0 may hold lock before it is forcibly broken.
- LOCK_CW, 7: lock timer width; must satisfy 2^LOCK_CW > LOCK_MAX.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0, req1  in  1  access request; held high until the matching done pulse
- we0, we1  in  1  1 = write, 0 = read; sampled at grant
- addr0, addr1  in  8  port address; sampled at grant
- wdata0, wdata1  in  8  write data; sampled at grant
- lock0  in  1  requester 0 holds the bus across consecutive transactions
- gnt0, gnt1  out  1  one-cycle pulse: request accepted
- done0, done1  out  1  one-cycle pulse: access complete
- rdata0, rdata1  out  8  read data; valid with done, held until that requester's next read completes
- lock_err  out  1  one-cycle pulse: lock forcibly broken
- busy  out  1  high whenever state is not IDLE
- Wr_Strobe  out  1  bus write strobe
- Rd_Strobe  out  1  bus read strobe
- AddrIn  out  8  bus port address
- DataIn  out  8  bus write data
- DataOut  in  8  bus read data; registered by the interface on AddrIn, valid the cycle after the address is presented

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_last = 1 (requester 0 wins the first tie); lock timer 0.
- States: IDLE, ISSUE, RDWAIT, DONE.
- IDLE, cycle T, selecting the winner:
  - If lock_owned (see lock rules) is set, only req0 is eligible.
  - Otherwise, if exactly one req is high, that requester wins.
  - If both are high, the requester != rr_last wins.
- IDLE, cycle T, on a winner:
  - Latch we, addr and wdata; set rr_last = winner.
  - Pulse gnt for the winner in cycle T+1.
  - Go to ISSUE.
- ISSUE (T+1):
  - Drive AddrIn = addr and DataIn = wdata.
  - Assert Wr_Strobe if we, else Rd_Strobe, for this cycle only.
  - Write: go to DONE. Read: go to RDWAIT.
- RDWAIT (T+2): AddrIn held; capture DataOut into the winner's rdata at the end of this cycle; go to DONE.
- DONE:
  - Pulse the winner's done; go to IDLE.
  - req is ignored in DONE; a requester must drop req or present a new access by the next IDLE cycle.
- Latency from req sampled in IDLE to done: 2 cycles for a write, 3 for a read.
- AddrIn and DataIn hold their last values when idle; strobes are 0 outside ISSUE.
- Lock rules:
  - lock_owned is set when a requester 0 transaction reaches DONE with lock0 = 1.
  - lock_owned is cleared when lock0 = 0 is sampled in IDLE.
  - While lock_owned, the lock timer increments every cycle and resets to 0 on clear.
  - When the timer reaches LOCK_MAX: clear lock_owned, pulse lock_err, and let requester 1 win the next arbitration even if it was rr_last.
- Simultaneous req0 and req1 in the cycle a lock is released: normal round-robin applies.
- Reset mid-transaction: abort immediately; no done pulse; no strobe in the following cycle.
- The rdata of the non-winning requester is never modified.

Decomposition:
- Shared package bot_if_pkg:
  - port-address constants (LEDs, digits, decimal points, MotCtl, LocX/LocY, BotInfo, Sensors, buttons, switches);
  - arbiter state encoding;
  - requester index constants.
- Natural sub-module: bot_rr_pick, the two-input round-robin/lock eligibility picker (combinational winner plus rr_last update).
- The FSM and datapath stay in the top module.

Test Plan:
- Single write: req0, we0 = 1, addr0 = 8'h09, wdata0 = 8'h33 → gnt0 at T+1; Wr_Strobe = 1 with AddrIn = 8'h09 and DataIn = 8'h33 at T+1 only; done0 at T+2.
- Single read: req1, we1 = 0, addr1 = 8'h0A, DataOut = 8'h5C on the cycle after ISSUE → Rd_Strobe at T+1; done1 at T+3 with rdata1 = 8'h5C; rdata0 unchanged.
- Contention: req0 and req1 both held from reset for 4 transactions → grants alternate 0,1,0,1; no cycle ever has both strobes high.
- Lock: lock0 = 1 during 3 back-to-back requester 0 reads of 8'h0A/0B/0C while req1 is held high → requester 1 gets no grant until lock0 drops; then gnt1 arrives within 2 cycles.
- Lock timeout: LOCK_MAX = 8, lock0 stuck high, req1 waiting → lock_err pulses once; the next grant is gnt1.
- Reset during RDWAIT → no done pulse; busy = 0 and strobes 0 the cycle after reset; the next request completes normally.
